// File: rtl/rv_subset_pkg.sv
// rtl/rv_subset_pkg.sv - shared widths, opcode, ALU-op and immediate-type encodings
package rv_subset_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int DIR_WIDTH  = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [6:0] {
    OP_ADDI = 7'b0010011,
    OP_ADD  = 7'b0110011,
    OP_BEQ  = 7'b1100011,
    OP_JAL  = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_PASS
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I,
    IMM_B,
    IMM_J
  } imm_type_e;

endpackage

// File: rtl/rv_subset_if.sv
// rtl/rv_subset_if.sv - instruction, write-back and debug signals between core and fetch source
interface rv_subset_if;
  import rv_subset_pkg::*;

  logic [DATA_WIDTH-1:0] instruction;
  logic [DATA_WIDTH-1:0] pc_o;
  logic [DATA_WIDTH-1:0] alu_result_o;
  logic                  rd_we_o;
  logic [DIR_WIDTH-1:0]  rd_addr_o;
  logic [DATA_WIDTH-1:0] rd_wdata_o;
  logic [DIR_WIDTH-1:0]  dbg_addr_i;
  logic [DATA_WIDTH-1:0] dbg_data_o;

  modport master (
    input  instruction,
    input  dbg_addr_i,
    output pc_o,
    output alu_result_o,
    output rd_we_o,
    output rd_addr_o,
    output rd_wdata_o,
    output dbg_data_o
  );

  modport slave (
    output instruction,
    output dbg_addr_i,
    input  pc_o,
    input  alu_result_o,
    input  rd_we_o,
    input  rd_addr_o,
    input  rd_wdata_o,
    input  dbg_data_o
  );

endinterface

// File: rtl/rv_subset_regfile.sv
// rtl/rv_subset_regfile.sv - 2R1W register file plus debug read port, x0 hardwired to zero
module rv_subset_regfile
  import rv_subset_pkg::*;
#(
  parameter int DATA_WIDTH = rv_subset_pkg::DATA_WIDTH,
  parameter int DIR_WIDTH  = rv_subset_pkg::DIR_WIDTH,
  parameter int NUM_REGS   = rv_subset_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DIR_WIDTH-1:0]  rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DIR_WIDTH-1:0]  rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  wr_en,
  input  logic [DIR_WIDTH-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DIR_WIDTH-1:0]  dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // x0 is masked on read so entry 0 never matters even if it were written
  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/rv_subset_core.sv
// rtl/rv_subset_core.sv - single-cycle ADDI/ADD/BEQ/JAL core: decode, immediates, ALU, next-PC
module rv_subset_core
  import rv_subset_pkg::*;
#(
  parameter int                     DATA_WIDTH = rv_subset_pkg::DATA_WIDTH,
  parameter int                     DIR_WIDTH  = rv_subset_pkg::DIR_WIDTH,
  parameter int                     NUM_REGS   = rv_subset_pkg::NUM_REGS,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = rv_subset_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          arst_n,
  rv_subset_if.master   bus
);

  logic [DATA_WIDTH-1:0] instr;
  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [DIR_WIDTH-1:0]  rd;
  logic [DIR_WIDTH-1:0]  rs1;
  logic [DIR_WIDTH-1:0]  rs2;

  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  imm_type_e             imm_type;
  logic [DATA_WIDTH-1:0] imm;
  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  wr_en;
  logic                  is_branch;
  logic                  is_jump;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  rd_we;

  assign instr  = bus.instruction;
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  rv_subset_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIR_WIDTH  (DIR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .arst_n   (arst_n),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .wr_en    (rd_we),
    .wr_addr  (rd),
    .wr_data  (wb_data),
    .dbg_addr (bus.dbg_addr_i),
    .dbg_data (bus.dbg_data_o)
  );

  always_comb begin
    imm_type = IMM_I;
    case (opcode)
      OP_BEQ:  imm_type = IMM_B;
      OP_JAL:  imm_type = IMM_J;
      default: imm_type = IMM_I;
    endcase
  end

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_B:   imm = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                      instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{(DATA_WIDTH-21){instr[31]}}, instr[31], instr[19:12],
                      instr[20], instr[30:21], 1'b0};
      default: imm = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    endcase
  end

  // Unrecognised encodings fall through with PASS of a zero operand, giving alu_result 0
  always_comb begin
    alu_op    = ALU_PASS;
    op_a      = '0;
    op_b      = '0;
    wr_en     = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (opcode)
      OP_ADDI: begin
        if (funct3 == 3'b000) begin
          alu_op = ALU_ADD;
          op_a   = rs1_data;
          op_b   = imm;
          wr_en  = 1'b1;
        end
      end
      OP_ADD: begin
        if ((funct3 == 3'b000) && (funct7 == 7'b0000000)) begin
          alu_op = ALU_ADD;
          op_a   = rs1_data;
          op_b   = rs2_data;
          wr_en  = 1'b1;
        end
      end
      OP_BEQ: begin
        if (funct3 == 3'b000) begin
          alu_op    = ALU_SUB;
          op_a      = rs1_data;
          op_b      = rs2_data;
          is_branch = 1'b1;
        end
      end
      OP_JAL: begin
        alu_op  = ALU_ADD;
        op_a    = pc;
        op_b    = imm;
        wr_en   = 1'b1;
        is_jump = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      default: alu_result = op_b;
    endcase
  end

  assign pc_plus4     = pc + DATA_WIDTH'(4);
  assign branch_taken = is_branch && (alu_result == '0);
  // The ALU is busy with the compare on BEQ, so the branch target has its own adder
  assign pc_next      = is_jump      ? alu_result :
                        branch_taken ? (pc + imm) : pc_plus4;
  assign wb_data      = is_jump ? pc_plus4 : alu_result;
  assign rd_we        = wr_en && (rd != '0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  assign bus.pc_o         = pc;
  assign bus.alu_result_o = alu_result;
  assign bus.rd_we_o      = rd_we;
  assign bus.rd_addr_o    = rd;
  assign bus.rd_wdata_o   = wb_data;

endmodule

// File: tb/tb_rv_subset_core.sv
// tb/tb_rv_subset_core.sv - directed-vector bench for rv_subset_core
module tb_rv_subset_core;

  logic clk;
  logic arst_n;
  int   vectors;
  int   miscompares;

  rv_subset_if bus ();

  rv_subset_core dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [16];

  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    bus.dbg_addr_i = a;
    #1;
    d = bus.dbg_data_o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    bus.instruction = 32'h0000_0000;
    arst_n = 1'b0;
    #2;
    vectors++;
    if (bus.pc_o !== 32'h0) begin
      miscompares++; $display("FAIL reset_pc actual=%h required=%h", bus.pc_o, 32'h0);
    end
    vectors++;
    if (bus.alu_result_o !== 32'h0 || bus.rd_we_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_outputs actual alu=%h we=%b required alu=0 we=0", bus.alu_result_o, bus.rd_we_o);
    end
    for (int r = 1; r < 32; r += 10) begin
      peek(r[4:0], d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++; $display("FAIL reset_reg%0d actual=%h required=0", r, d);
      end
    end
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_addi();
    logic [31:0] d;
    bus.instruction = 32'h0050_0093;
    #1;
    vectors++;
    if (bus.rd_we_o !== 1'b1 || bus.rd_addr_o !== 5'd1 || bus.rd_wdata_o !== 32'd5) begin
      miscompares++; $display("FAIL addi_wb actual we=%b rd=%0d data=%h required we=1 rd=1 data=5", bus.rd_we_o, bus.rd_addr_o, bus.rd_wdata_o);
    end
    step();
    peek(5'd1, d);
    vectors++;
    if (d !== 32'd5 || bus.pc_o !== 32'd4) begin
      miscompares++; $display("FAIL addi_result actual x1=%h pc=%h required x1=5 pc=4", d, bus.pc_o);
    end
  endtask

  task automatic test_add();
    logic [31:0] d;
    bus.instruction = 32'hFFF0_0113;
    step();
    bus.instruction = 32'h0020_81B3;
    #1;
    vectors++;
    if (bus.alu_result_o !== 32'd4) begin
      miscompares++; $display("FAIL add_alu actual=%h required=4", bus.alu_result_o);
    end
    step();
    peek(5'd2, d);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL addi_neg x2 actual=%h required=ffffffff", d);
    end
    peek(5'd3, d);
    vectors++;
    if (d !== 32'd4 || bus.pc_o !== 32'd12) begin
      miscompares++; $display("FAIL add_wrap actual x3=%h pc=%h required x3=4 pc=c", d, bus.pc_o);
    end
  endtask

  task automatic test_beq();
    logic [31:0] d;
    bus.instruction = 32'h0050_0213;
    step();
    bus.instruction = 32'h0040_8463;
    #1;
    vectors++;
    if (bus.alu_result_o !== 32'h0 || bus.rd_we_o !== 1'b0) begin
      miscompares++; $display("FAIL beq_taken_comb actual alu=%h we=%b required alu=0 we=0", bus.alu_result_o, bus.rd_we_o);
    end
    step();
    vectors++;
    if (bus.pc_o !== 32'd24) begin
      miscompares++; $display("FAIL beq_taken_pc actual=%h required=18", bus.pc_o);
    end
    peek(5'd4, d);
    vectors++;
    if (d !== 32'd5) begin
      miscompares++; $display("FAIL beq_no_write x4 actual=%h required=5", d);
    end
    bus.instruction = 32'h0020_8463;
    #1;
    vectors++;
    if (bus.alu_result_o !== 32'd6 || bus.rd_we_o !== 1'b0) begin
      miscompares++; $display("FAIL beq_not_taken_comb actual alu=%h we=%b required alu=6 we=0", bus.alu_result_o, bus.rd_we_o);
    end
    step();
    vectors++;
    if (bus.pc_o !== 32'd28) begin
      miscompares++; $display("FAIL beq_not_taken_pc actual=%h required=1c", bus.pc_o);
    end
  endtask

  task automatic test_jal();
    logic [31:0] d;
    pulse_reset();
    bus.instruction = 32'h0000_0013;
    repeat (4) step();
    vectors++;
    if (bus.pc_o !== 32'd16) begin
      miscompares++; $display("FAIL jal_setup_pc actual=%h required=10", bus.pc_o);
    end
    bus.instruction = 32'hFFDF_F2EF;
    #1;
    vectors++;
    if (bus.alu_result_o !== 32'd12 || bus.rd_wdata_o !== 32'd20 || bus.rd_we_o !== 1'b1) begin
      miscompares++; $display("FAIL jal_comb actual alu=%h wdata=%h we=%b required alu=c wdata=14 we=1", bus.alu_result_o, bus.rd_wdata_o, bus.rd_we_o);
    end
    step();
    peek(5'd5, d);
    vectors++;
    if (d !== 32'd20 || bus.pc_o !== 32'd12) begin
      miscompares++; $display("FAIL jal_back actual x5=%h pc=%h required x5=14 pc=c", d, bus.pc_o);
    end
    bus.instruction = 32'h0080_006F;
    #1;
    vectors++;
    if (bus.rd_we_o !== 1'b0) begin
      miscompares++; $display("FAIL jal_x0_we actual=%b required=0", bus.rd_we_o);
    end
    step();
    peek(5'd0, d);
    vectors++;
    if (d !== 32'h0 || bus.pc_o !== 32'd20) begin
      miscompares++; $display("FAIL jal_x0 actual x0=%h pc=%h required x0=0 pc=14", d, bus.pc_o);
    end
  endtask

  task automatic test_nop();
    logic [31:0] d;
    logic [31:0] nops [3];
    logic [31:0] pc_exp;
    nops[0] = 32'h0070_0013;
    nops[1] = 32'h0000_007F;
    nops[2] = 32'h4020_8233;
    pc_exp  = bus.pc_o;
    for (int k = 0; k < 3; k++) begin
      bus.instruction = nops[k];
      #1;
      vectors++;
      if (bus.rd_we_o !== 1'b0) begin
        miscompares++; $display("FAIL nop%0d_we actual=%b required=0", k, bus.rd_we_o);
      end
      if (k > 0) begin
        vectors++;
        if (bus.alu_result_o !== 32'h0) begin
          miscompares++; $display("FAIL nop%0d_alu actual=%h required=0", k, bus.alu_result_o);
        end
      end
      step();
      pc_exp = pc_exp + 32'd4;
      vectors++;
      if (bus.pc_o !== pc_exp) begin
        miscompares++; $display("FAIL nop%0d_pc actual=%h required=%h", k, bus.pc_o, pc_exp);
      end
    end
    peek(5'd0, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("FAIL nop_x0 actual=%h required=0", d);
    end
    peek(5'd4, d);
    vectors++;
    if (d !== 32'h0) begin
      miscompares++; $display("FAIL nop_sub_no_write x4 actual=%h required=0", d);
    end
  endtask

  task automatic load_fib_rom();
    for (int i = 0; i < 16; i++) rom[i] = 32'h0000_0013;
    rom[0] = 32'h0000_0093;
    rom[1] = 32'h0010_0113;
    rom[2] = 32'h00D0_0313;
    rom[3] = 32'h0060_8A63;
    rom[4] = 32'h0020_81B3;
    rom[5] = 32'h0001_00B3;
    rom[6] = 32'h0001_8133;
    rom[7] = 32'hFF1F_F06F;
    rom[8] = 32'h0000_006F;
  endtask

  task automatic test_fibonacci();
    logic [31:0] fib_exp [8];
    logic [31:0] d;
    int          n;
    bit          done;
    fib_exp = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13};
    load_fib_rom();
    pulse_reset();
    n    = 0;
    done = 1'b0;
    bus.dbg_addr_i = 5'd1;
    for (int c = 0; c < 200 && !done; c++) begin
      bus.instruction = rom[bus.pc_o[5:2]];
      #1;
      if (bus.pc_o == 32'd12) begin
        vectors++;
        if (n >= 8 || bus.dbg_data_o !== fib_exp[n]) begin
          miscompares++; $display("FAIL fib_seq[%0d] actual=%0d required=%0d", n, bus.dbg_data_o, (n < 8) ? fib_exp[n] : 32'hFFFF_FFFF);
        end
        n++;
      end
      step();
      if (bus.pc_o == 32'd32) done = 1'b1;
    end
    vectors++;
    if (!done || n !== 8) begin
      miscompares++; $display("FAIL fib_exit actual done=%0d samples=%0d required done=1 samples=8", done, n);
    end
    peek(5'd2, d);
    vectors++;
    if (d !== 32'd21) begin
      miscompares++; $display("FAIL fib_x2 actual=%0d required=21", d);
    end
  endtask

  task automatic test_reset_mid_loop();
    logic [31:0] d;
    load_fib_rom();
    pulse_reset();
    for (int c = 0; c < 17; c++) begin
      bus.instruction = rom[bus.pc_o[5:2]];
      step();
    end
    peek(5'd6, d);
    vectors++;
    if (d !== 32'd13) begin
      miscompares++; $display("FAIL midrst_pre_x6 actual=%0d required=13", d);
    end
    arst_n = 1'b0;
    #1;
    vectors++;
    if (bus.pc_o !== 32'h0) begin
      miscompares++; $display("FAIL midrst_pc actual=%h required=0", bus.pc_o);
    end
    for (int r = 1; r <= 6; r++) begin
      peek(r[4:0], d);
      vectors++;
      if (d !== 32'h0) begin
        miscompares++; $display("FAIL midrst_x%0d actual=%h required=0", r, d);
      end
    end
    @(negedge clk);
    arst_n = 1'b1;
    bus.instruction = rom[1];
    step();
    peek(5'd2, d);
    vectors++;
    if (bus.pc_o !== 32'd4 || d !== 32'd1) begin
      miscompares++; $display("FAIL midrst_first_edge actual pc=%h x2=%h required pc=4 x2=1", bus.pc_o, d);
    end
  endtask

  initial begin
    vectors         = 0;
    miscompares     = 0;
    arst_n          = 1'b0;
    bus.instruction = 32'h0;
    bus.dbg_addr_i  = 5'd0;
    test_reset();
    test_addi();
    test_add();
    test_beq();
    test_jal();
    test_nop();
    test_fibonacci();
    test_reset_mid_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_subset_core.md
Name: rv_subset_core

Overview:
- Single-cycle RV32I-subset execution core: ADDI, ADD, BEQ, JAL.
- The instruction word is supplied each cycle on an input port by the fetch source or bench; there is no internal instruction memory.
- The core owns the PC, a 32x32 register file, immediate generation, ALU and next-PC selection.
- It is the datapath/control block used to run the Fibonacci program in the processor top.

Parameters:
- DATA_WIDTH, 32, width of registers, PC, ALU and instruction.
- DIR_WIDTH, 5, register address width.
- NUM_REGS, 32, register file depth.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  asynchronous active-low reset.
- instruction  in  DATA_WIDTH  instruction executed in the current cycle.
- pc_o  out  DATA_WIDTH  current PC (fetch address).
- alu_result_o  out  DATA_WIDTH  combinational ALU output for the current instruction.
- rd_we_o  out  1  register write enable this cycle (already qualified for rd!=0).
- rd_addr_o  out  DIR_WIDTH  destination register.
- rd_wdata_o  out  DATA_WIDTH  write-back data.
- dbg_addr_i  in  DIR_WIDTH  debug register read address.
- dbg_data_o  out  DATA_WIDTH  combinational read of reg[dbg_addr_i]; x0 always reads 0.

Behaviour:
- Reset (arst_n=0, asynchronous): pc=RESET_PC and all registers=0. Outputs then reflect the combinational decode of the current instruction with zero operands.
- Timing: single cycle. Decode, register read, ALU and next-PC are combinational from instruction and state. PC and register write update on the rising clk edge. Results are visible one edge after the instruction is applied.
- Field decode: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- ADDI (0010011), funct3 must be 000: rd = rs1 + sext(instr[31:20]); pc += 4.
- ADD (0110011), funct3=000 and funct7=0000000: rd = rs1 + rs2; pc += 4.
- BEQ (1100011), funct3 must be 000:
  - imm = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - pc += imm if rs1==rs2, else pc += 4.
  - No register write.
  - The ALU compares via subtraction; alu_result_o = rs1-rs2.
- JAL (1101111):
  - rd = pc+4.
  - pc += sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - alu_result_o = pc+imm.
- Any other opcode or funct combination: NOP. No write, pc += 4, alu_result_o = 0.
- x0 is hardwired to zero. Writes to rd=0 are suppressed (rd_we_o=0); reads of x0 return 0.
- Arithmetic is 32-bit modulo 2^32; overflow wraps silently. PC wraps modulo 2^32.
- Register read and write in the same cycle: the read returns the old value (no bypass needed in single-cycle).
- Reset asserted mid-operation: state clears immediately. The first edge after release executes the instruction present at that time.

Decomposition:
- Shared package rv_subset_pkg holds:
  - DATA_WIDTH, DIR_WIDTH.
  - opcode enum: OP_ADDI=7'b0010011, OP_ADD=7'b0110011, OP_BEQ=7'b1100011, OP_JAL=7'b1101111.
  - ALU-op enum: ADD, SUB, PASS.
  - Immediate-type enum: I, B, J.
- One sub-module: rv_subset_regfile, with two async read ports, one sync write port, the debug read port and x0 forced to zero.
- Control, immediate generation, ALU and PC muxing stay inline in rv_subset_core.

Test Plan:
- Reset, then apply ADDI x1,x0,5 (32'h00500093) -> after 1 edge reg[1]=5, pc=4.
- ADDI x2,x0,-1 (32'hFFF00113) then ADD x3,x1,x2 (32'h002081B3) -> reg[2]=32'hFFFFFFFF, reg[3]=4, pc=12.
- BEQ taken:
  - With x1=x4=5, apply BEQ x1,x4,+8 at pc=P -> pc=P+8, no register changes.
  - With x1!=x2, apply the BEQ -> pc=P+4.
- JAL x5,-4 at pc=16 -> reg[5]=20, pc=12. Also JAL x0,+8 -> no write, pc advances by 8.
- ADDI x0,x0,7 and an undefined opcode 32'h0000007F -> reg[0] stays 0, rd_we_o=0, pc += 4 each.
- Fibonacci loop using ADDI/ADD/BEQ/JAL -> dbg_data_o shows 0,1,1,2,3,5,8,13 in sequence. Then assert arst_n=0 mid-loop -> pc=0 and all registers 0 immediately.
